// File: rtl/ifu_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory req/gnt/rvalid port, EX redirect and decoder handoff.
interface ifu_fetch_if;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        id_ready_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] addr_o;

    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, id_ready_i
    );
endinterface

// File: rtl/ifu_fetch.sv
// RV32I instruction fetch: PC owner, req/gnt/rvalid issue, in-order fetch queue, redirect flush.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    ifu_fetch_if.master      bus
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    entry_t            q_mem [FIFO_DEPTH];
    logic [31:0]       a_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  q_rd;
    logic [PTR_W-1:0]  q_wr;
    logic [PTR_W-1:0]  a_rd;
    logic [PTR_W-1:0]  a_wr;
    logic [CNT_W-1:0]  q_cnt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  discard;
    logic [31:0]       pc;

    logic              q_nonempty;
    logic              pop_req;
    logic              pop;
    logic              push;
    logic              fire;
    logic              rsp;
    logic              req;
    logic [OCC_W-1:0]  occ;
    entry_t            head;

    // Issue/retire decisions; occupancy counts in-flight plus queued words net of this cycle's pop.
    always_comb begin
        head       = q_mem[q_rd];
        q_nonempty = (q_cnt != '0);
        pop_req    = q_nonempty && bus.id_ready_i;
        occ        = OCC_W'(outstanding) + OCC_W'(q_cnt) - OCC_W'(pop_req);
        req        = !rst && !bus.redirect_i && (occ < OCC_W'(FIFO_DEPTH));
        fire       = req && bus.imem_gnt_i;
        rsp        = bus.imem_rvalid_i;
        push       = rsp && (discard == '0) && !bus.redirect_i;
        pop        = pop_req && !bus.redirect_i;
    end

    assign bus.imem_req_o   = req;
    assign bus.imem_addr_o  = pc;
    assign bus.inst_valid_o = q_nonempty;
    assign bus.inst_o       = q_nonempty ? head.word : NOP;
    assign bus.addr_o       = q_nonempty ? head.pc   : 32'h0000_0000;

    // PC, in-flight bookkeeping and queue pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            q_rd        <= '0;
            q_wr        <= '0;
            a_rd        <= '0;
            a_wr        <= '0;
            q_cnt       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (bus.redirect_i) begin
                pc <= bus.redirect_pc_i & 32'hFFFF_FFFC;
            end else if (fire) begin
                pc <= pc + 32'd4;
            end

            outstanding <= outstanding + CNT_W'(fire) - CNT_W'(rsp);

            // Everything still in flight after this cycle's retirement becomes stale.
            if (bus.redirect_i) begin
                discard <= outstanding - CNT_W'(rsp);
            end else if (rsp && (discard != '0)) begin
                discard <= discard - CNT_W'(1);
            end

            if (fire) begin
                a_wr <= a_wr + PTR_W'(1);
            end
            if (rsp) begin
                a_rd <= a_rd + PTR_W'(1);
            end

            if (bus.redirect_i) begin
                q_rd  <= '0;
                q_wr  <= '0;
                q_cnt <= '0;
            end else begin
                if (push) begin
                    q_wr <= q_wr + PTR_W'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + PTR_W'(1);
                end
                q_cnt <= q_cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage: request PCs in issue order, fetched words paired with their PC.
    always_ff @(posedge clk) begin
        if (fire) begin
            a_mem[a_wr] <= pc;
        end
        if (push) begin
            q_mem[q_wr] <= '{word: bus.imem_rdata_i, pc: a_mem[a_rd]};
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an in-order variable-latency memory and a delivery reference model.
module tb_ifu_fetch;

    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ifu_fetch_if bus();

    ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          drop;
    } pend_t;

    pend_t       pending[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          last_due;
    int          model_cnt;
    int          lat_fixed;
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    logic        o_req;
    logic        o_valid;
    logic [31:0] o_iaddr;
    logic [31:0] o_inst;
    logic [31:0] o_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic g, input logic r, input logic rd, input logic [31:0] rpc);
        bus.imem_gnt_i    = g;
        bus.id_ready_i    = r;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = rpc;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = 32'h0;
        pending.delete();
        model_cnt  = 0;
        exp_pc     = 32'h0;
        exp_req_pc = 32'h0;
        last_due   = -1;
        #1;
        chk("rst_req",   bus.imem_req_o,   32'h0);
        chk("rst_valid", bus.inst_valid_o, 32'h0);
        chk("rst_inst",  bus.inst_o,       NOP);
        chk("rst_addr",  bus.addr_o,       32'h0);
        chk("rst_pc",    bus.imem_addr_o,  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // One clock: serve memory, sample DUT, update reference model, advance.
    task automatic do_cycle();
        bit    rsp;
        pend_t e;
        int    lat;
        int    due;
        rsp = (pending.size() > 0) && (pending[0].due <= cyc);
        bus.imem_rvalid_i = rsp;
        bus.imem_rdata_i  = rsp ? mem_word(pending[0].addr) : 32'hDEAD_BEEF;
        #1;
        o_req   = bus.imem_req_o;
        o_iaddr = bus.imem_addr_o;
        o_valid = bus.inst_valid_o;
        o_inst  = bus.inst_o;
        o_addr  = bus.addr_o;
        chk("valid_model", o_valid, model_cnt != 0);
        if (o_req && bus.imem_gnt_i) chk("req_addr", o_iaddr, exp_req_pc);
        if (o_valid && bus.id_ready_i && !bus.redirect_i) begin
            chk("pop_addr", o_addr, exp_pc);
            chk("pop_inst", o_inst, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            model_cnt--;
        end
        if (rsp) begin
            e = pending.pop_front();
            if (!e.drop && !bus.redirect_i) model_cnt++;
        end
        if (o_req && bus.imem_gnt_i) begin
            lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 3));
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pending.push_back('{addr: o_iaddr, due: due, drop: 1'b0});
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (bus.redirect_i) begin
            for (int i = 0; i < pending.size(); i++) pending[i].drop = 1'b1;
            model_cnt  = 0;
            exp_pc     = bus.redirect_pc_i & 32'hFFFF_FFFC;
            exp_req_pc = exp_pc;
        end
        chk("occupancy", 32'((pending.size() + model_cnt) <= FIFO_DEPTH), 32'h1);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lat_fixed = 1;
        do_reset();

        // Streaming: one request and one delivered instruction per cycle after fill.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 1'b0, 32'h0);
            do_cycle();
            chk("t1_req",   o_req,   32'h1);
            chk("t1_iaddr", o_iaddr, 32'(4 * k));
            chk("t1_valid", o_valid, 32'(k >= 2));
            if (k >= 2) chk("t1_addr", o_addr, 32'(4 * (k - 2)));
        end

        // Decoder stall for 5 cycles, entered through a mid-operation reset.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, (k < 2) || (k >= 7), 1'b0, 32'h0);
            do_cycle();
            if (k >= 2 && k <= 6) begin
                chk("t2_hold_valid", o_valid, 32'h1);
                chk("t2_hold_addr",  o_addr,  32'h0);
            end
            if (k >= 3 && k <= 6) chk("t2_req_off", o_req, 32'h0);
            if (k >= 7) chk("t2_release_addr", o_addr, 32'(4 * (k - 7)));
        end

        // Redirect with two requests outstanding at 3-cycle latency.
        do_reset();
        lat_fixed = 3;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b1, k == 2, 32'h0000_0103);
            do_cycle();
            if (k == 2) chk("t3_redir_req", o_req, 32'h0);
            if (k == 3) begin
                chk("t3_new_pc",  o_iaddr, 32'h0000_0100);
                chk("t3_full_req", o_req,  32'h0);
            end
            if (k == 4) begin
                chk("t3_req",   o_req,   32'h1);
                chk("t3_iaddr", o_iaddr, 32'h0000_0100);
            end
            if (k >= 3 && k <= 7) chk("t3_no_stale", o_valid, 32'h0);
            if (k == 8) begin
                chk("t3_valid", o_valid, 32'h1);
                chk("t3_addr",  o_addr,  32'h0000_0100);
            end
        end

        // Redirect on rvalid, redirect over a held request, then PC wrap.
        do_reset();
        lat_fixed = 1;
        for (int k = 0; k < 12; k++) begin
            drive(!(k == 2 || k == 3), 1'b1, (k == 1) || (k == 3) || (k == 7),
                  (k == 1) ? 32'h0000_0200 : (k == 3) ? 32'h0000_0300 : 32'hFFFF_FFFF);
            do_cycle();
            if (k == 1) chk("t4_redir_req", o_req, 32'h0);
            if (k == 2) begin
                chk("t4_resume_req",   o_req,   32'h1);
                chk("t4_resume_iaddr", o_iaddr, 32'h0000_0200);
                chk("t4_dropped",      o_valid, 32'h0);
            end
            if (k == 3) chk("t4_held_redir_req", o_req, 32'h0);
            if (k == 4) begin
                chk("t4_req2",   o_req,   32'h1);
                chk("t4_iaddr2", o_iaddr, 32'h0000_0300);
                chk("t4_valid2", o_valid, 32'h0);
            end
            if (k == 6) begin
                chk("t4_valid3", o_valid, 32'h1);
                chk("t4_addr3",  o_addr,  32'h0000_0300);
                chk("t4_inst3",  o_inst,  mem_word(32'h0000_0300));
            end
            if (k == 8) begin
                chk("t5_req_top",   o_req,   32'h1);
                chk("t5_iaddr_top", o_iaddr, 32'hFFFF_FFFC);
            end
            if (k == 9) chk("t5_iaddr_wrap", o_iaddr, 32'h0000_0000);
            if (k == 10) begin
                chk("t5_addr_top",  o_addr,  32'hFFFF_FFFC);
                chk("t5_valid_top", o_valid, 32'h1);
            end
            if (k == 11) chk("t5_addr_wrap", o_addr, 32'h0000_0000);
        end

        // Random grant, latency and back-pressure with periodic redirects.
        do_reset();
        lat_fixed = 0;
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, (k % 23) == 22, $urandom);
            do_cycle();
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h0);
            do_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
